// File: rtl/pooling_pkg.sv
// ============================================================================
//  Module      : pooling_pkg
//  Description : Shared types and elaboration helpers for the streaming pooler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pooling_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_t;

  // log2 of the window size; only 2 and 4 are legal, anything else maps to 1
  function automatic int pool_log2(input int pool);
    return (pool == 4) ? 2 : 1;
  endfunction

  function automatic bit pool_params_ok(input int img_w, input int img_h, input int pool);
    return ((pool == 2) || (pool == 4)) && ((img_w % pool) == 0) && ((img_h % pool) == 0)
           && (img_w >= pool) && (img_h >= pool);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pooling_acc_bank.sv
// ============================================================================
//  Module      : pooling_acc_bank
//  Description : One accumulator per window column; loads, sums or keeps max.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pooling_acc_bank
  import pooling_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int POOL   = 2,
  parameter int N_ACC  = 14,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_first,
  input  pool_mode_t               i_mode,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic signed [DATA_W-1:0] i_pixel,
  output logic signed [DATA_W-1:0] o_result
);

  localparam int c_SHIFT = 2 * pool_log2(POOL);
  localparam int c_ACC_W = DATA_W + c_SHIFT;

  logic signed [c_ACC_W-1:0] r_acc [N_ACC];
  logic signed [c_ACC_W-1:0] w_cur;
  logic signed [c_ACC_W-1:0] w_px_ext;
  logic signed [c_ACC_W-1:0] w_comb;

  assign w_cur    = r_acc[i_idx];
  assign w_px_ext = {{c_SHIFT{i_pixel[DATA_W-1]}}, i_pixel};

  always_comb begin
    w_comb = w_px_ext;
    if (!i_first) begin
      if (i_mode == POOL_AVG) begin
        w_comb = w_cur + w_px_ext;
      end else if (w_px_ext > w_cur) begin
        w_comb = w_px_ext;
      end else begin
        w_comb = w_cur;
      end
    end
  end

  // Arithmetic shift by c_SHIFT then truncation is exactly the top DATA_W bits
  assign o_result = (i_mode == POOL_AVG) ? w_comb[c_ACC_W-1:c_SHIFT] : w_comb[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ACC; i++) begin
        r_acc[i] <= '0;
      end
    end else if (i_en) begin
      r_acc[i_idx] <= w_comb;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pooling_stream.sv
// ============================================================================
//  Module      : pooling_stream
//  Description : Streaming POOLxPOOL average/max pooling over a raster image.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pooling_stream
  import pooling_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_pixel,
  output logic                     busy,
  output logic                     finish
);

  localparam int c_LOG_P = pool_log2(POOL);
  localparam int c_N_ACC = IMG_W / POOL;
  localparam int c_IDX_W = (c_N_ACC > 1) ? $clog2(c_N_ACC) : 1;
  localparam int c_COL_W = $clog2(IMG_W);
  localparam int c_ROW_W = $clog2(IMG_H);

  if (!pool_params_ok(IMG_W, IMG_H, POOL)) begin : g_param_check
    $error("pooling_stream: POOL must be 2 or 4 and divide IMG_W and IMG_H");
  end

  pool_state_t               r_state;
  pool_mode_t                r_mode;
  logic [c_COL_W-1:0]        r_col;
  logic [c_ROW_W-1:0]        r_row;
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_out_pixel;

  logic                      w_in_hs;
  logic                      w_out_hs;
  logic                      w_first;
  logic                      w_win_last;
  logic                      w_frame_last;
  logic [c_IDX_W-1:0]        w_idx;
  logic signed [DATA_W-1:0]  w_result;

  // Stall input while a result is waiting so the output register is never overwritten
  assign in_ready     = (r_state == ST_RUN) && !(r_out_valid && !out_ready);
  assign w_in_hs      = in_valid && in_ready;
  assign w_out_hs     = r_out_valid && out_ready;
  assign w_first      = (r_row[c_LOG_P-1:0] == '0) && (r_col[c_LOG_P-1:0] == '0);
  assign w_win_last   = (&r_row[c_LOG_P-1:0]) && (&r_col[c_LOG_P-1:0]);
  assign w_frame_last = (r_row == c_ROW_W'(IMG_H - 1)) && (r_col == c_COL_W'(IMG_W - 1));
  assign w_idx        = c_IDX_W'(r_col >> c_LOG_P);

  pooling_acc_bank #(
    .DATA_W (DATA_W),
    .POOL   (POOL),
    .N_ACC  (c_N_ACC),
    .IDX_W  (c_IDX_W)
  ) u_acc_bank (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_in_hs),
    .i_first  (w_first),
    .i_mode   (r_mode),
    .i_idx    (w_idx),
    .i_pixel  (in_pixel),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= POOL_AVG;
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
    end else begin
      if (w_in_hs && w_win_last) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= w_result;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      if (w_in_hs) begin
        if (r_col == c_COL_W'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_W'(IMG_H - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_mode  <= pool_mode_t'(mode);
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        ST_RUN: begin
          if (w_in_hs && w_frame_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign finish    = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/pooling_stream.md
POOLING_STREAM -- requirements
Module: pooling_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed pixel width.
REQ-002 SHALL have parameter IMG_W, default 28, image columns; must be a multiple of POOL.
REQ-003 SHALL have parameter IMG_H, default 28, image rows; must be a multiple of POOL.
REQ-004 SHALL have parameter POOL, default 2, window size and stride; legal values 2 and 4.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port start  input  1  begins a frame when sampled high in IDLE.
REQ-008 SHALL have port mode  input  1  0 = average, 1 = max; sampled at start.
REQ-009 SHALL have port in_valid  input  1  in_pixel valid.
REQ-010 SHALL have port in_ready  output  1  pixel accepted when in_valid && in_ready.
REQ-011 SHALL have port in_pixel  input  DATA_W  signed pixel, raster order, row-major.
REQ-012 SHALL have port out_valid  output  1  out_pixel valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 SHALL have port out_pixel  output  DATA_W  signed pooled result.
REQ-015 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-016 SHALL have port finish  output  1  one-cycle pulse at frame completion.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1); DRAIN->DONE on final output handshake; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL latch mode at the IDLE->RUN transition and hold it for the whole frame.
REQ-020 SHALL drive in_ready = (state==RUN) && !(out_valid && !out_ready).
REQ-021 SHALL keep column and row counters; column wraps IMG_W-1 -> 0 and increments row.
REQ-022 SHALL hold IMG_W/POOL accumulators of width DATA_W+2*log2(POOL); accumulator index = col/POOL.
REQ-023 SHALL load (not combine) an accumulator on the first pixel of its window (row%POOL==0, col%POOL==0), else add (average) or signed-compare-keep-larger (max).
REQ-024 SHALL, on acceptance of the last pixel of a window, register the result into the output register and assert out_valid the next cycle (latency 1).
REQ-025 SHALL compute average as arithmetic right shift of the sum by 2*log2(POOL) (floor), truncated to DATA_W; max is exact.
REQ-026 SHALL hold out_valid and out_pixel stable until out_ready is high.
REQ-027 SHALL allow a new window result into the output register in the same cycle the old one handshakes.
REQ-028 SHALL emit exactly (IMG_W/POOL)*(IMG_H/POOL) outputs per frame, raster order.
REQ-029 SHALL pulse finish for exactly the DONE cycle.
REQ-030 SHALL fail elaboration if POOL not in {2,4} or IMG_W, IMG_H not multiples of POOL.

Reset
REQ-031 SHALL, on rst high at a clock edge, enter IDLE, clear counters, accumulators and latched mode, and drive in_ready=0, out_valid=0, out_pixel=0, busy=0, finish=0, regardless of state; a frame in progress is discarded.

Structure
REQ-032 SHALL take pool_mode_t (POOL_AVG=0, POOL_MAX=1) and the state enum from shared package pooling_pkg.
REQ-033 SHALL place the accumulator bank and combine logic in sub-module pooling_acc_bank.

Verification
REQ-034 SHALL check reset: rst during RUN -> next cycle IDLE, all outputs 0, no finish.
REQ-035 SHALL check 4x4 image, POOL=2, avg, pixels 0..15 raster, out_ready=1 -> outputs 2,4,10,12 then finish one cycle after the last handshake.
REQ-036 SHALL check same image in max mode -> outputs 5,7,13,15.
REQ-037 SHALL check signed avg window {-1,-2,-3,-4} -> -3 (floor of -2.5); max of same -> -1.
REQ-038 SHALL check backpressure: out_ready held 0 for 10 cycles -> in_ready 0 while out_valid pending, out_pixel stable, no output lost or duplicated.
REQ-039 SHALL check 8x8 image, POOL=4, avg, all pixels 99 -> four outputs of 99; start pulsed mid-frame is ignored.
